// File: rtl/response_encoder_pkg.sv
// Shared definitions for the response encoder: word widths, VLQ chunk thresholds
// and the encoder state encoding.
package response_encoder_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ID_WIDTH      = 8;
  localparam int VLQ_MAX_BYTES = 5;

  // Chunk k (k = 1..4, counted from the least significant) is needed when
  // v < -2^(7k-2) or v >= 3*2^(7k-2).
  localparam int signed VLQ_LO_1 = -(1 << 5);
  localparam int signed VLQ_HI_1 = 3 * (1 << 5);
  localparam int signed VLQ_LO_2 = -(1 << 12);
  localparam int signed VLQ_HI_2 = 3 * (1 << 12);
  localparam int signed VLQ_LO_3 = -(1 << 19);
  localparam int signed VLQ_HI_3 = 3 * (1 << 19);
  localparam int signed VLQ_LO_4 = -(1 << 26);
  localparam int signed VLQ_HI_4 = 3 * (1 << 26);

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,
    EMIT_ID    = 2'd1,
    EMIT_PARAM = 2'd2
  } encState_e;

endpackage

// File: rtl/response_encoder_if.sv
// Parameter-collection and byte-stream signals of the response encoder.
interface response_encoder_if;
  import response_encoder_pkg::*;

  logic [DATA_WIDTH-1:0] param_data;
  logic                  param_write;
  logic                  cmd_done;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  overflow;

  modport slave (
    input  param_data, param_write, cmd_done, out_ready,
    output out_data, out_valid, out_last, busy, overflow
  );

  modport master (
    output param_data, param_write, cmd_done, out_ready,
    input  out_data, out_valid, out_last, busy, overflow
  );

endinterface

// File: rtl/vlq_split.sv
// Splits a 32-bit signed value into its VLQ byte count and the five candidate
// bytes, indexed by chunk (index 0 is the final byte, index 4 the top chunk).
module vlq_split
  import response_encoder_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]             value_i,
  output logic [2:0]                        byteCount_o,
  output logic [VLQ_MAX_BYTES-1:0][7:0]     candBytes_o
);

  logic signed [DATA_WIDTH-1:0] v;
  logic needChunk1, needChunk2, needChunk3, needChunk4;

  assign v = value_i;

  always_comb begin
    needChunk4 = (v < VLQ_LO_4) || (v >= VLQ_HI_4);
    needChunk3 = needChunk4 || (v < VLQ_LO_3) || (v >= VLQ_HI_3);
    needChunk2 = needChunk3 || (v < VLQ_LO_2) || (v >= VLQ_HI_2);
    needChunk1 = needChunk2 || (v < VLQ_LO_1) || (v >= VLQ_HI_1);

    byteCount_o = 3'd1;
    if (needChunk4)      byteCount_o = 3'd5;
    else if (needChunk3) byteCount_o = 3'd4;
    else if (needChunk2) byteCount_o = 3'd3;
    else if (needChunk1) byteCount_o = 3'd2;

    // The top chunk reaches past bit 31, so it is filled with the sign.
    candBytes_o[4] = {1'b1, {3{v[31]}}, v[31:28]};
    candBytes_o[3] = {1'b1, v[27:21]};
    candBytes_o[2] = {1'b1, v[20:14]};
    candBytes_o[1] = {1'b1, v[13:7]};
    candBytes_o[0] = {1'b0, v[6:0]};
  end

endmodule

// File: rtl/response_encoder.sv
// Collects parameter words, then streams the response id and the parameters
// as VLQ bytes over a valid/ready byte interface.
module response_encoder
  import response_encoder_pkg::*;
#(
  parameter int MAX_PARAMS = 8
) (
  input logic               clk,
  input logic               rst,
  response_encoder_if.slave enc
);

  localparam int AW = $clog2(MAX_PARAMS);
  localparam int CW = AW + 1;

  encState_e             state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wordIdx_q, wordIdx_d;
  logic [2:0]            byteIdx_q, byteIdx_d;
  logic [ID_WIDTH-1:0]   respId_q, respId_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] paramMem [MAX_PARAMS];
  logic                  memWe;

  logic [DATA_WIDTH-1:0]             splitIn;
  logic [2:0]                        byteCount;
  logic [2:0]                        chunkSel;
  logic [VLQ_MAX_BYTES-1:0][7:0]     candBytes;
  logic                              emitting, lastByte, lastWord, outLast, fire;

  // Outputs come straight from the cursor registers, so a stalled byte holds
  // without a separate output stage and the next word follows with no bubble.
  assign emitting = (state_q != COLLECT);
  assign splitIn  = (state_q == EMIT_ID) ? {{(DATA_WIDTH-ID_WIDTH){1'b0}}, respId_q}
                                         : paramMem[wordIdx_q];

  vlq_split uSplit (
    .value_i     (splitIn),
    .byteCount_o (byteCount),
    .candBytes_o (candBytes)
  );

  assign chunkSel = byteCount - 3'd1 - byteIdx_q;
  assign lastByte = (byteIdx_q + 3'd1) == byteCount;
  assign lastWord = (CW'(wordIdx_q) + CW'(1)) == count_q;
  assign outLast  = emitting && lastByte &&
                    ((state_q == EMIT_ID) ? (count_q == '0) : lastWord);
  assign fire     = emitting && enc.out_ready;

  assign enc.out_valid = emitting;
  assign enc.out_data  = emitting ? candBytes[chunkSel] : 8'h00;
  assign enc.out_last  = outLast;
  assign enc.busy      = emitting;
  assign enc.overflow  = overflow_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wordIdx_d  = wordIdx_q;
    byteIdx_d  = byteIdx_q;
    respId_d   = respId_q;
    overflow_d = overflow_q;
    memWe      = 1'b0;

    case (state_q)
      COLLECT: begin
        if (enc.cmd_done) begin
          respId_d  = enc.param_data[ID_WIDTH-1:0];
          wordIdx_d = '0;
          byteIdx_d = '0;
          state_d   = EMIT_ID;
        end else if (enc.param_write) begin
          if (count_q == CW'(MAX_PARAMS)) begin
            overflow_d = 1'b1;
          end else begin
            memWe   = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        if (enc.param_write || enc.cmd_done) overflow_d = 1'b1;
        if (fire) begin
          if (!lastByte) begin
            byteIdx_d = byteIdx_q + 3'd1;
          end else begin
            byteIdx_d = '0;
            if (outLast) begin
              state_d   = COLLECT;
              count_d   = '0;
              wordIdx_d = '0;
            end else if (state_q == EMIT_ID) begin
              state_d = EMIT_PARAM;
            end else begin
              wordIdx_d = wordIdx_q + AW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      count_q    <= '0;
      wordIdx_q  <= '0;
      byteIdx_q  <= '0;
      respId_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wordIdx_q  <= wordIdx_d;
      byteIdx_q  <= byteIdx_d;
      respId_q   <= respId_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) paramMem[count_q[AW-1:0]] <= enc.param_data;
  end

endmodule

// File: doc/response_encoder.md
RESPONSE_ENCODER -- requirements
Module: response_encoder

Parameters
REQ-001 MAX_PARAMS, default 8: depth of the 32-bit parameter buffer (power of two, 2..32).

Interface
REQ-002 clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 param_data  input  32  a parameter word while param_write=1; the response id (low 8 bits) on the cmd_done cycle.
REQ-005 param_write  input  1  accept param_data as the next parameter word.
REQ-006 cmd_done  input  1  one-cycle pulse that closes the response; param_data[7:0] is the response id.
REQ-007 out_data  output  8  encoded payload byte.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  downstream framer accepts the byte.
REQ-010 out_last  output  1  qualifies the final byte of a response.
REQ-011 busy  output  1  high from the cmd_done cycle until the last byte is accepted.
REQ-012 overflow  output  1  sticky error flag; cleared only by rst.

Function
REQ-013 States: COLLECT, EMIT_ID, EMIT_PARAM.
- COLLECT is the reset state.
- busy=0 only in COLLECT.
REQ-014 COLLECT, param_write=1, count<MAX_PARAMS: store the word at index count, then increment count.
REQ-015 COLLECT, param_write=1, count==MAX_PARAMS: drop the word and set overflow.
REQ-016 COLLECT, cmd_done=1:
- latch param_data[7:0] as the response id;
- go to EMIT_ID;
- busy rises on the next cycle.
- param_write on the same cycle is ignored.
REQ-017 The first out_valid occurs exactly 1 cycle after cmd_done.
REQ-018 Emission order: the response id, then parameters in write order, each encoded as described in REQ-019 and REQ-020.
REQ-019 Encoding (signed 32-bit VLQ), evaluated most-significant chunk first, with v = the word as int32:
- a: v < -2^26 or v >= 3*2^26: emit 0x80 | v[34:28] (sign-extended).
- b: a applies, or v < -2^19, or v >= 3*2^19: emit 0x80 | v[27:21].
- c: b applies, or v < -2^12, or v >= 3*2^12: emit 0x80 | v[20:14].
- d: c applies, or v < -2^5, or v >= 3*2^5: emit 0x80 | v[13:7].
- Always emit v[6:0] as the final byte with bit 7 clear.
REQ-020 The response id is encoded the same way, as a zero-extended unsigned value, so 1 or 2 bytes.
REQ-021 Handshake:
- A byte transfers when out_valid && out_ready.
- out_data, out_valid and out_last are held stable while out_valid && !out_ready.
- out_valid never drops without a transfer.
- With out_ready held high, the block sustains 1 byte per cycle, including across word boundaries.
REQ-022 out_last=1 only on the final byte of the last parameter, or on the final id byte when count==0.
REQ-023 After the out_last transfer:
- go to COLLECT;
- clear count;
- busy=0 on the next cycle.
- overflow is unaffected.
REQ-024 Any param_write or cmd_done while busy=1 is ignored and sets overflow.
REQ-025 An upstream param_write on the cycle busy falls is accepted normally.

Reset
REQ-026 While rst=1, every register reaches its default in one clk:
- state=COLLECT, count=0, out_valid=0, out_last=0, out_data=0, busy=0, overflow=0.
REQ-027 A reset mid-response discards the partially emitted message with no further bytes; the downstream framer owns recovery.
REQ-028 Buffer RAM contents need no reset.

Structure
REQ-029 The shared protocol package holds:
- the VLQ threshold constants;
- the response id width (8);
- the encoder state encoding.
REQ-030 A combinational sub-module vlq_split SHALL be used:
- input: a 32-bit value;
- outputs: the byte count (1..5) and five candidate bytes.
- The encoder instantiates it once, on the buffer read port.

Verification
REQ-031 Bench scenario: write 1, cmd_done id=5, out_ready=1 -> bytes 0x05, 0x01 on consecutive cycles; out_last on 0x01; busy high for 2 cycles after cmd_done.
REQ-032 Bench scenario: write 100, write -1 (0xFFFFFFFF), cmd_done id=3 -> 0x03, 0x80, 0x64, 0x7F; out_last on 0x7F.
REQ-033 Bench scenario: write 0x12345678, cmd_done id=0x84 -> 0x81, 0x04, 0x81, 0x91, 0xD1, 0xAC, 0x78.
REQ-034 Bench scenario: random out_ready stalls with 4 params -> byte sequence identical to the no-stall run; outputs stable during stalls.
REQ-035 Bench scenario: MAX_PARAMS+2 writes, then cmd_done id=1 -> exactly MAX_PARAMS params emitted; overflow=1; a param_write while busy leaves overflow=1 and the output unchanged.
REQ-036 Bench scenario: rst asserted after the 2nd emitted byte -> out_valid=0 on the next cycle; a following write 2, cmd_done id=7 yields 0x07, 0x02.
